// File: rtl/conv_l2_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : conv_l2_sequencer
// Purpose  : Layer-2 convolution control FSM; steps the address generator
//            through X/Y/Z phases per output row and pulses acc/write-back.
// Revision : 1.0
// ============================================================================
module conv_l2_sequencer #(
    parameter int ROWS = 11,
    parameter int XLEN = 16,
    parameter int YLEN = 4,
    parameter int ZLEN = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [6:0] i_base_x,
    input  logic [6:0] i_base_y,
    input  logic [6:0] i_base_z,
    input  logic       i_stall,
    input  logic       i_done_adr,
    output logic [6:0] o_x,
    output logic [6:0] o_y,
    output logic [6:0] o_z,
    output logic       o_ld_adr,
    output logic [1:0] o_sel_adr,
    output logic       o_rst_x_adr,
    output logic       o_acc_clr,
    output logic       o_acc_en,
    output logic       o_wr_en,
    output logic       o_busy,
    output logic       o_done
);

    localparam logic [5:0] c_X_LAST   = 6'(XLEN - 1);
    localparam logic [5:0] c_Y_LAST   = 6'(YLEN - 1);
    localparam logic [5:0] c_Z_LAST   = 6'(ZLEN - 1);
    localparam logic [3:0] c_ROWS     = 4'(ROWS);
    localparam logic [1:0] c_SEL_X    = 2'b00;
    localparam logic [1:0] c_SEL_Y    = 2'b01;
    localparam logic [1:0] c_SEL_Z    = 2'b10;
    localparam logic [1:0] c_SEL_HOLD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_XPH  = 3'd2,
        S_YPH  = 3'd3,
        S_ZPH  = 3'd4,
        S_WR   = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    state_t     w_ph_next;
    logic [5:0] r_ph_cnt;
    logic [5:0] w_ph_cnt_nxt;
    logic [5:0] w_ph_last;
    logic [1:0] w_ph_sel;
    logic [3:0] r_row_cnt;
    logic [3:0] w_row_cnt_nxt;
    logic [6:0] r_x;
    logic [6:0] r_y;
    logic [6:0] r_z;
    logic       r_acc_en;
    logic       w_ld;
    logic [1:0] w_sel;
    logic       w_rst_x;
    logic       w_acc_clr;
    logic       w_wr_en;

    // Per-phase length, select code and successor, shared by the three phase states
    always_comb begin
        w_ph_last = c_X_LAST;
        w_ph_sel  = c_SEL_X;
        w_ph_next = S_YPH;
        case (r_state)
            S_YPH: begin
                w_ph_last = c_Y_LAST;
                w_ph_sel  = c_SEL_Y;
                w_ph_next = S_ZPH;
            end
            S_ZPH: begin
                w_ph_last = c_Z_LAST;
                w_ph_sel  = c_SEL_Z;
                w_ph_next = S_WR;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_ph_cnt_nxt  = r_ph_cnt;
        w_row_cnt_nxt = r_row_cnt;
        w_ld          = 1'b0;
        w_sel         = c_SEL_HOLD;
        w_rst_x       = 1'b0;
        w_acc_clr     = 1'b0;
        w_wr_en       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_ld          = 1'b1;
                w_rst_x       = 1'b1;
                w_acc_clr     = 1'b1;
                w_ph_cnt_nxt  = '0;
                w_row_cnt_nxt = '0;
                w_state_nxt   = S_XPH;
            end
            S_XPH, S_YPH, S_ZPH: begin
                if (!i_stall) begin
                    w_sel = w_ph_sel;
                    if (r_ph_cnt == w_ph_last) begin
                        w_ph_cnt_nxt = '0;
                        w_state_nxt  = w_ph_next;
                    end else begin
                        w_ph_cnt_nxt = r_ph_cnt + 6'd1;
                    end
                end
            end
            S_WR: begin
                // Write and clear share the cycle; the write sees the pre-clear sum
                w_wr_en       = 1'b1;
                w_acc_clr     = 1'b1;
                w_row_cnt_nxt = r_row_cnt + 4'd1;
                if ((r_row_cnt + 4'd1 == c_ROWS) || i_done_adr) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_rst_x     = 1'b1;
                    w_state_nxt = S_XPH;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_ph_cnt  <= '0;
            r_row_cnt <= '0;
            r_acc_en  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ph_cnt  <= w_ph_cnt_nxt;
            r_row_cnt <= w_row_cnt_nxt;
            // Generator registers the address, so data returns one cycle later
            r_acc_en  <= (w_sel != c_SEL_HOLD);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= '0;
            r_y <= '0;
            r_z <= '0;
        end else if ((r_state == S_IDLE) && i_start) begin
            r_x <= i_base_x;
            r_y <= i_base_y;
            r_z <= i_base_z;
        end
    end

    assign o_x         = r_x;
    assign o_y         = r_y;
    assign o_z         = r_z;
    assign o_ld_adr    = w_ld;
    assign o_sel_adr   = w_sel;
    assign o_rst_x_adr = w_rst_x;
    assign o_acc_clr   = w_acc_clr;
    assign o_acc_en    = r_acc_en;
    assign o_wr_en     = w_wr_en;
    assign o_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    assign o_done      = (r_state == S_DONE);

endmodule
`default_nettype wire
